// File: rtl/wb_rr_mux.sv
// wb_rr_mux: CH-input registered selector with round-robin or fixed-priority
// arbitration feeding a one-entry output register with valid/ready handshake.
module wb_rr_mux #(
  parameter int unsigned W         = 32,
  parameter int unsigned CH        = 4,
  parameter int unsigned PRIO_MODE = 0,
  localparam int unsigned SW       = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH*W-1:0] in_data,
  input  logic [CH-1:0]   in_valid,
  output logic [CH-1:0]   in_ready,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_sel,
  output logic            out_valid,
  input  logic            out_ready
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state;
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] grant;
  logic          found;
  logic          load_en;
  logic [W-1:0]  sel_data;

  assign out_valid = (state == FULL);
  assign load_en   = !out_valid || out_ready;

  // Search upward from rr_ptr (or from 0 in fixed mode), wrapping at CH.
  always_comb begin
    int unsigned idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < CH; i++) begin
      idx = (PRIO_MODE != 0) ? i : 32'(rr_ptr) + i;
      if (idx >= CH) idx = idx - CH;
      if (!found && in_valid[SW'(idx)]) begin
        found = 1'b1;
        grant = SW'(idx);
      end
    end
  end

  // Select the granted channel's word.
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      if (grant == SW'(k)) sel_data = in_data[k*W +: W];
    end
  end

  // Accept only the granted, valid channel while the register can load.
  always_comb begin
    in_ready = '0;
    if (load_en && found) in_ready[grant] = 1'b1;
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      rr_ptr   <= '0;
    end else if (load_en && found) begin
      state    <= FULL;
      out_data <= sel_data;
      out_sel  <= grant;
      if (PRIO_MODE == 0)
        rr_ptr <= (grant == SW'(CH-1)) ? '0 : grant + SW'(1);
    end else if (out_valid && out_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_wb_rr_mux.sv
// tb_wb_rr_mux: three instances (RR CH=4, fixed CH=4, RR CH=3) driven by
// directed and random stimulus and compared each cycle with a reference model.
module tb_wb_rr_mux;

  logic clk;
  logic rst_n;

  logic [3:0]       iv   [3];
  logic [3:0][15:0] id   [3];
  logic             ordy [3];
  logic [3:0]       ir   [3];
  logic [15:0]      od   [3];
  logic [1:0]       os   [3];
  logic             ov   [3];
  logic [2:0]       ir3;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          chn  [3] = '{4, 4, 3};
  int          fixd [3] = '{0, 1, 0};
  int          mv   [3];
  logic [15:0] md   [3];
  int          ms   [3];
  int          mp   [3];

  wb_rr_mux #(.W(16), .CH(4), .PRIO_MODE(0)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .in_data(id[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .out_data(od[0]), .out_sel(os[0]), .out_valid(ov[0]), .out_ready(ordy[0]));

  wb_rr_mux #(.W(16), .CH(4), .PRIO_MODE(1)) u_fp4 (
    .clk(clk), .rst_n(rst_n), .in_data(id[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .out_data(od[1]), .out_sel(os[1]), .out_valid(ov[1]), .out_ready(ordy[1]));

  wb_rr_mux #(.W(16), .CH(3), .PRIO_MODE(0)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .in_data(id[2][2:0]), .in_valid(iv[2][2:0]), .in_ready(ir3),
    .out_data(od[2]), .out_sel(os[2]), .out_valid(ov[2]), .out_ready(ordy[2]));

  assign ir[2] = {1'b0, ir3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mv[i] = 0; md[i] = '0; ms[i] = 0; mp[i] = 0;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    int          nv [3];
    logic [15:0] nd [3];
    int          ns [3];
    int          np [3];
    #1;
    for (int i = 0; i < 3; i++) begin
      int g;
      int load;
      logic [3:0] exp_rdy;
      g = -1;
      for (int off = 0; off < chn[i]; off++) begin
        int k;
        k = fixd[i] ? off : (mp[i] + off) % chn[i];
        if (g < 0 && iv[i][k]) g = k;
      end
      load = (mv[i] == 0) || ordy[i];
      exp_rdy = (load && g >= 0) ? 4'(1 << g) : 4'b0;
      chk($sformatf("in_ready[%0d]", i), 32'(ir[i]), 32'(exp_rdy));
      chk($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(mv[i]));
      chk($sformatf("out_data[%0d]", i), 32'(od[i]), 32'(md[i]));
      chk($sformatf("out_sel[%0d]", i), 32'(os[i]), 32'(ms[i]));
      nv[i] = mv[i]; nd[i] = md[i]; ns[i] = ms[i]; np[i] = mp[i];
      if (load && g >= 0) begin
        nv[i] = 1; nd[i] = id[i][g]; ns[i] = g;
        if (!fixd[i]) np[i] = (g + 1) % chn[i];
      end else if (mv[i] != 0 && ordy[i]) begin
        nv[i] = 0;
      end
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      mv[i] = nv[i]; md[i] = nd[i]; ms[i] = ns[i]; mp[i] = np[i];
    end
    @(negedge clk);
  endtask

  task automatic drive_all(input logic [3:0] v, input logic r);
    for (int i = 0; i < 3; i++) begin
      iv[i] = v; ordy[i] = r;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 4; k++) id[i][k] = 16'h1000 + 16'(k);
    drive_all(4'b0000, 1'b1);
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_out_valid", 32'(ov[i]), 32'd0);
      chk("rst_out_data",  32'(od[i]), 32'd0);
      chk("rst_in_ready",  32'(ir[i]), 32'd0);
    end
    rst_n = 1'b1;

    // round-robin fairness: all valid, one beat per cycle
    drive_all(4'b1111, 1'b1);
    for (int c = 0; c < 8; c++) begin
      step();
      chk("rr_seq_sel", 32'(os[0]), 32'(c % 4));
      chk("rr_seq_data", 32'(od[0]), 32'h1000 + 32'(c % 4));
      chk("fp_all_sel", 32'(os[1]), 32'd0);
    end

    // fixed priority: channel 3 starved while channel 1 is valid
    drive_all(4'b1010, 1'b1);
    for (int c = 0; c < 6; c++) begin
      step();
      chk("fp_sel1", 32'(os[1]), 32'd1);
    end

    // backpressure
    drive_all(4'b0100, 1'b1);
    step();
    drive_all(4'b0100, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_data", 32'(od[0]), 32'h1002);
      chk("bp_valid", 32'(ov[0]), 32'd1);
    end
    drive_all(4'b0100, 1'b1);
    #1 chk("bp_release_ready", 32'(ir[0]), 32'b0100);
    @(negedge clk);
    step();
    step();

    // wrap on CH=3: put pointer at 2, then 011 grants 0 then 1
    drive_all(4'b0010, 1'b1);
    step();
    drive_all(4'b0011, 1'b1);
    step();
    chk("wrap_first", 32'(os[2]), 32'd0);
    step();
    chk("wrap_second", 32'(os[2]), 32'd1);

    // drain without refill
    drive_all(4'b0000, 1'b1);
    step();
    step();
    chk("drain_valid", 32'(ov[0]), 32'd0);
    chk("drain_hold", 32'(od[0]), 32'h1001);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 3) != 0) iv[i] = 4'($urandom);
        for (int k = 0; k < 4; k++)
          if ($urandom_range(0, 1) != 0) id[i][k] = 16'($urandom);
        ordy[i] = ($urandom_range(0, 3) != 0);
      end
      step();
    end

    // asynchronous reset mid-stream with held beats
    drive_all(4'b1111, 1'b0);
    step();
    drive_all(4'b0000, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("midrst_valid", 32'(ov[i]), 32'd0);
      chk("midrst_data",  32'(od[i]), 32'd0);
      chk("midrst_sel",   32'(os[i]), 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_all(4'b1111, 1'b1);
    step();
    chk("post_rst_sel", 32'(os[0]), 32'd0);
    step();
    chk("post_rst_sel2", 32'(os[0]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
